// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer sequencing controller:
// FSM state encoding, display message codes and the LFSR seed/taps.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RUN,
    DONE,
    CHEAT,
    TIMEOUT
  } state_t;

  typedef enum logic [1:0] {
    MSG_NONE    = 2'd0,
    MSG_CHEAT   = 2'd1,
    MSG_TIMEOUT = 2'd2,
    MSG_VALID   = 2'd3
  } msg_t;

  // Right-shifting Fibonacci LFSR; taps 16,14,13,11 map to bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam logic [3:0] BCD_NINE = 4'd9;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

  // Result states: the game is over and only clear leaves them.
  function automatic logic is_final(input state_t s);
    return (s == DONE) || (s == CHEAT) || (s == TIMEOUT);
  endfunction

endpackage

// File: rtl/bcd3_counter.sv
// Three-digit BCD up-counter with ripple carry units -> tens -> hundreds.
// 'terminal' flags the count one below the reaction limit so the caller
// can stop before the limit value is ever displayed.
module bcd3_counter
  import reaction_pkg::*;
#(
  parameter int unsigned TERMINAL = 999
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       terminal
);

  localparam logic [11:0] TERM_BCD = {4'((TERMINAL / 100) % 10),
                                      4'((TERMINAL / 10) % 10),
                                      4'(TERMINAL % 10)};

  logic [3:0] d2_q, d1_q, d0_q;
  logic [3:0] d2_d, d1_d, d0_d;

  // Next count: clear wins over increment; each digit wraps 9 -> 0 and carries.
  always_comb begin
    d2_d = d2_q;
    d1_d = d1_q;
    d0_d = d0_q;
    if (clr) begin
      d2_d = '0;
      d1_d = '0;
      d0_d = '0;
    end else if (inc) begin
      if (d0_q == BCD_NINE) begin
        d0_d = '0;
        if (d1_q == BCD_NINE) begin
          d1_d = '0;
          d2_d = (d2_q == BCD_NINE) ? 4'd0 : d2_q + 4'd1;
        end else begin
          d1_d = d1_q + 4'd1;
        end
      end else begin
        d0_d = d0_q + 4'd1;
      end
    end
  end

  // Digit registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d2_q <= '0;
      d1_q <= '0;
      d0_q <= '0;
    end else begin
      d2_q <= d2_d;
      d1_q <= d1_d;
      d0_q <= d0_d;
    end
  end

  assign d2       = d2_q;
  assign d1       = d1_q;
  assign d0       = d0_q;
  assign terminal = ({d2_q, d1_q, d0_q} == TERM_BCD);

endmodule

// File: rtl/reaction_seq_ctrl.sv
// Reaction-timer sequencing controller: button edge detect, pseudo-random
// wait, stimulus LED, millisecond BCD reaction count, cheat/timeout flags.
// Optional build macro BEST_TIME_EN adds a best-result register with
// best_d2/best_d1/best_d0 and a one-cycle new_best pulse.
module reaction_seq_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned DELAY_MIN_MS = 2000,
  parameter int unsigned DELAY_BITS   = 11,
  parameter int unsigned TIMEOUT_MS   = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  output logic       led,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic [1:0] msg,
  output logic       busy,
  output logic       done_tick
`ifdef BEST_TIME_EN
  ,
  output logic [3:0] best_d2,
  output logic [3:0] best_d1,
  output logic [3:0] best_d0,
  output logic       new_best
`endif
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DELAY_MIN_MS + (1 << DELAY_BITS));

  state_t        state_q, state_d;
  logic          start_q, stop_q, clr_q;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] delay_q, delay_d;
  logic          done_tick_q, done_tick_d;

  logic          start_rise, stop_rise, clr_rise, ms_tick;
  logic          cnt_clr, cnt_inc, cnt_term;
  logic [3:0]    cnt_h, cnt_t, cnt_u;
  msg_t          msg_code;

  assign start_rise = start & ~start_q;
  assign stop_rise  = stop & ~stop_q;
  assign clr_rise   = clr & ~clr_q;
  assign ms_tick    = (presc_q == PW'(TICK_DIV - 1));
  assign lfsr_d     = lfsr_next(lfsr_q);

  bcd3_counter #(
    .TERMINAL (TIMEOUT_MS - 1)
  ) u_count (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .d2       (cnt_h),
    .d1       (cnt_t),
    .d0       (cnt_u),
    .terminal (cnt_term)
  );

  // Next-state logic: clear beats everything, then button rises, then ms timers.
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    presc_d = ms_tick ? '0 : presc_q + PW'(1);
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (clr_rise) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_rise) begin
            delay_d = DW'(DELAY_MIN_MS) + DW'(lfsr_q[DELAY_BITS-1:0]);
            cnt_clr = 1'b1;
            presc_d = '0;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (stop_rise) begin
            state_d = CHEAT;
          end else if (ms_tick) begin
            if (delay_q == '0) begin
              presc_d = '0;
              state_d = RUN;
            end else begin
              delay_d = delay_q - DW'(1);
            end
          end
        end
        RUN: begin
          // A stop on the same cycle as the limit tick is still a valid result.
          if (stop_rise) begin
            state_d = DONE;
          end else if (ms_tick) begin
            if (cnt_term) begin
              state_d = TIMEOUT;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    done_tick_d = is_final(state_d) && !is_final(state_q);
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      clr_q       <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      presc_q     <= '0;
      delay_q     <= '0;
      done_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      stop_q      <= stop;
      clr_q       <= clr;
      lfsr_q      <= lfsr_d;
      presc_q     <= presc_d;
      delay_q     <= delay_d;
      done_tick_q <= done_tick_d;
    end
  end

  // Message code follows the current result state.
  always_comb begin
    msg_code = MSG_NONE;
    case (state_q)
      DONE:    msg_code = MSG_VALID;
      CHEAT:   msg_code = MSG_CHEAT;
      TIMEOUT: msg_code = MSG_TIMEOUT;
      default: msg_code = MSG_NONE;
    endcase
  end

  assign led       = (state_q == RUN);
  assign busy      = (state_q == WAIT) || (state_q == RUN);
  assign msg       = msg_code;
  assign done_tick = done_tick_q;
  assign d2        = (state_q == TIMEOUT) ? BCD_NINE : cnt_h;
  assign d1        = (state_q == TIMEOUT) ? BCD_NINE : cnt_t;
  assign d0        = (state_q == TIMEOUT) ? BCD_NINE : cnt_u;

`ifdef BEST_TIME_EN
  logic [11:0] best_q, best_d;
  logic        new_best_q, new_best_d;

  // Packed BCD compares numerically, so a plain '<' is the lexicographic test.
  always_comb begin
    best_d     = best_q;
    new_best_d = 1'b0;
    if ((state_q == RUN) && (state_d == DONE) && ({cnt_h, cnt_t, cnt_u} < best_q)) begin
      best_d     = {cnt_h, cnt_t, cnt_u};
      new_best_d = 1'b1;
    end
  end

  // Best result survives clear; only reset restores 999.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      best_q     <= {BCD_NINE, BCD_NINE, BCD_NINE};
      new_best_q <= 1'b0;
    end else begin
      best_q     <= best_d;
      new_best_q <= new_best_d;
    end
  end

  assign best_d2  = best_q[11:8];
  assign best_d1  = best_q[7:4];
  assign best_d0  = best_q[3:0];
  assign new_best = new_best_q;
`endif

endmodule
